// File: rtl/clock_divider_ctrl.sv
// -----------------------------------------------------------------------------
// clock_divider_ctrl
//
// Run-time controller for a slowed-down clock path. Produces a divided clock
// (clock_out) and a one-cycle period tick from the fast clock_in, under the
// control of a start/stop state machine. The divisor is programmed through a
// valid/ready port; while dividing, a new value is parked in a one-entry
// pending slot and only copied into the active divisor at a period boundary,
// so no runt or stretched slow-clock pulse is ever generated.
//
// Optional feature macro: CLKCTRL_PERIOD_COUNT_EN
//   When defined, a 16-bit period_count output counts slow periods started
//   (increments with every tick, wraps, cleared only by reset).
//
// Parameters
//   WIDTH            width of divisor and period counter
//   DEFAULT_DIVISOR  active divisor after reset
//   MIN_DIVISOR      smallest legal divisor (must be >= 2)
//
// Ports
//   clock_in      in   fast clock, all logic on its rising edge
//   reset         in   synchronous active-high reset
//   start         in   level request to begin / resume dividing
//   stop          in   level request to stop at end of current period
//   cfg_valid     in   divisor offered
//   cfg_divisor   in   offered divisor (unsigned, WIDTH bits)
//   cfg_ready     out  controller can accept a divisor
//   cfg_error     out  one-cycle pulse: last accepted divisor was illegal
//   clock_out     out  divided clock
//   tick          out  high in the first fast cycle of each slow period
//   running       out  high while in RUN or STOPPING
//   period_count  out  slow periods started (macro builds only)
// -----------------------------------------------------------------------------
module clock_divider_ctrl #(
    parameter int          WIDTH           = 28,
    parameter int unsigned DEFAULT_DIVISOR = 100000,
    parameter int unsigned MIN_DIVISOR     = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_divisor,
    output logic             cfg_ready,
    output logic             cfg_error,
    output logic             clock_out,
    output logic             tick,
    output logic             running
`ifdef CLKCTRL_PERIOD_COUNT_EN
    ,
    output logic [15:0]      period_count
`endif
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] MIN_D = WIDTH'(MIN_DIVISOR);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] counter_reg, counter_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic             pending_valid_reg, pending_valid_next;
    logic [WIDTH-1:0] pending_divisor_reg, pending_divisor_next;
    logic             clock_out_reg, clock_out_next;
    logic             tick_reg, tick_next;
    logic             running_reg, running_next;
    logic             cfg_ready_reg, cfg_ready_next;
    logic             cfg_error_reg, cfg_error_next;

    logic             cfg_fire;
    logic             cfg_legal;
    logic             period_end;
    logic             apply_pending;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            counter_reg         <= '0;
            divisor_reg         <= DEF_D;
            pending_valid_reg   <= 1'b0;
            pending_divisor_reg <= '0;
            clock_out_reg       <= 1'b0;
            tick_reg            <= 1'b0;
            running_reg         <= 1'b0;
            cfg_ready_reg       <= 1'b1;
            cfg_error_reg       <= 1'b0;
        end else begin
            state_reg           <= state_next;
            counter_reg         <= counter_next;
            divisor_reg         <= divisor_next;
            pending_valid_reg   <= pending_valid_next;
            pending_divisor_reg <= pending_divisor_next;
            clock_out_reg       <= clock_out_next;
            tick_reg            <= tick_next;
            running_reg         <= running_next;
            cfg_ready_reg       <= cfg_ready_next;
            cfg_error_reg       <= cfg_error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next           = state_reg;
        counter_next         = counter_reg;
        divisor_next         = divisor_reg;
        pending_valid_next   = pending_valid_reg;
        pending_divisor_next = pending_divisor_reg;

        cfg_fire   = cfg_valid && cfg_ready_reg;
        cfg_legal  = (cfg_divisor >= MIN_D);
        period_end = (state_reg != ST_IDLE) &&
                     (counter_reg == (divisor_reg - WIDTH'(1)));

        case (state_reg)
            ST_IDLE: begin
                counter_next = '0;
                // stop has priority over start in the same cycle
                if (start && !stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                counter_next = period_end ? '0 : counter_reg + WIDTH'(1);
                if (stop) begin
                    state_next = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                counter_next = period_end ? '0 : counter_reg + WIDTH'(1);
                // A resume keeps the counter running undisturbed; only a
                // period end without resume drops back to IDLE.
                if (start && !stop) begin
                    state_next = ST_RUN;
                end else if (period_end) begin
                    state_next   = ST_IDLE;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                counter_next = '0;
            end
        endcase

        // A parked divisor is copied at the period boundary. The IDLE term
        // only covers a value that slipped into the slot on the very edge
        // that ended the last period; it is applied one cycle later.
        apply_pending = pending_valid_reg && (period_end || state_reg == ST_IDLE);
        if (apply_pending) begin
            divisor_next       = pending_divisor_reg;
            pending_valid_next = 1'b0;
        end

        // cfg_ready is low whenever the slot is occupied, so a legal transfer
        // never collides with an occupied slot.
        if (cfg_fire && cfg_legal) begin
            if (state_reg == ST_IDLE) begin
                divisor_next = cfg_divisor;
            end else begin
                pending_valid_next   = 1'b1;
                pending_divisor_next = cfg_divisor;
            end
        end

        cfg_error_next = cfg_fire && !cfg_legal;
        // Held low through the copy edge as well, so ready reappears in the
        // cycle after the new divisor has taken over.
        cfg_ready_next = !pending_valid_next && !apply_pending;

        // Outputs are registered versions of what the next cycle looks like,
        // computed against the divisor that the next cycle will use.
        running_next   = (state_next != ST_IDLE);
        tick_next      = running_next && (counter_next == '0);
        clock_out_next = running_next && (counter_next < (divisor_next >> 1));
    end

    assign cfg_ready = cfg_ready_reg;
    assign cfg_error = cfg_error_reg;
    assign clock_out = clock_out_reg;
    assign tick      = tick_reg;
    assign running   = running_reg;

`ifdef CLKCTRL_PERIOD_COUNT_EN
    logic [15:0] period_count_reg;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            period_count_reg <= '0;
        end else if (tick_next) begin
            period_count_reg <= period_count_reg + 16'd1;
        end
    end

    assign period_count = period_count_reg;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_ctrl
//
// Self-checking bench for clock_divider_ctrl (DEFAULT_DIVISOR overridden to 6).
// Each scenario task queues the per-cycle expected output vector
// {clock_out, tick, running, cfg_ready, cfg_error} as it plans its stimulus,
// then drives the stimulus and pops one expectation per fast cycle.
// -----------------------------------------------------------------------------
module tb_clock_divider_ctrl;

    localparam int WIDTH = 28;

    logic             clock_in = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_divisor;
    logic             cfg_ready;
    logic             cfg_error;
    logic             clock_out;
    logic             tick;
    logic             running;
`ifdef CLKCTRL_PERIOD_COUNT_EN
    logic [15:0]      period_count;
`endif

    clock_divider_ctrl #(
        .WIDTH           (WIDTH),
        .DEFAULT_DIVISOR (6),
        .MIN_DIVISOR     (2)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .cfg_valid    (cfg_valid),
        .cfg_divisor  (cfg_divisor),
        .cfg_ready    (cfg_ready),
        .cfg_error    (cfg_error),
        .clock_out    (clock_out),
        .tick         (tick),
        .running      (running)
`ifdef CLKCTRL_PERIOD_COUNT_EN
        ,
        .period_count (period_count)
`endif
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int passed = 0;

    logic [4:0] sb[$];

    localparam logic [4:0] IDLE_VEC = 5'b00010;

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        stop        = 1'b0;
        cfg_valid   = 1'b0;
        cfg_divisor = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    // Expected vector for cycle k of a running period of length d.
    function automatic logic [4:0] wave(input int d, input int k,
                                        input logic rdy, input logic err);
        logic co;
        logic tk;
        co = (k < d / 2);
        tk = (k == 0);
        return {co, tk, 1'b1, rdy, err};
    endfunction

    function automatic logic [4:0] observed();
        return {clock_out, tick, running, cfg_ready, cfg_error};
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] got;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        got = observed();
        checks++;
        if (got !== IDLE_VEC)
            $display("FAIL reset_outputs: got %b expected %b", got, IDLE_VEC);
        else
            passed++;
`ifdef CLKCTRL_PERIOD_COUNT_EN
        checks++;
        if (period_count !== 16'd0)
            $display("FAIL reset_period_count: got %0d expected 0", period_count);
        else
            passed++;
`endif
        reset = 1'b0;
        $display("txn reset: outputs %b", got);
    endtask

    // Default divisor 6: three full periods.
    task automatic test_default_run();
        logic [4:0] got, e;
        do_reset();
        for (int j = 0; j < 18; j++) sb.push_back(wave(6, j % 6, 1'b1, 1'b0));
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) start = 1'b1;
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL default_run cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
        $display("txn default_run: 18 cycles of D=6");
    endtask

    // Program 5 in IDLE, then start.
    task automatic test_idle_cfg();
        logic [4:0] got, e;
        do_reset();
        sb.push_back(IDLE_VEC);
        for (int j = 0; j < 10; j++) sb.push_back(wave(5, j % 5, 1'b1, 1'b0));
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 5;
            end
            if (i == 1) start = 1'b1;
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL idle_cfg cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
        $display("txn idle_cfg: D=5 programmed in IDLE");
    endtask

    // D=8 running, 4 offered at counter=2; applied at the next boundary.
    task automatic test_reconfig();
        logic [4:0] got, e;
        do_reset();
        sb.push_back(IDLE_VEC);
        for (int j = 0; j < 8; j++)  sb.push_back(wave(8, j, (j <= 2), 1'b0));
        for (int j = 8; j < 20; j++) sb.push_back(wave(4, (j - 8) % 4, (j != 8), 1'b0));
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 8;
            end
            if (i == 1) start = 1'b1;
            // edge 4 closes run cycle 2 (counter=2)
            if (i == 4) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 4;
            end
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL reconfig cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
        $display("txn reconfig: D=8 -> 4 at period boundary");
    endtask

    // Illegal divisors are rejected with a single error pulse.
    task automatic test_cfg_error();
        logic [4:0] got, e;
        do_reset();
        for (int j = 0; j < 18; j++)
            sb.push_back(wave(6, j % 6, 1'b1, (j == 2) || (j == 9)));
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) start = 1'b1;
            if (i == 2) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 1;
            end
            if (i == 9) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 0;
            end
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL cfg_error cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
        $display("txn cfg_error: divisors 1 and 0 rejected");
    endtask

    // D=4; stop (optionally with start) sampled at counter=1 of period 1,
    // optional resume at counter=2 of the stopping period.
    task automatic run_stop_case(input string name, input logic both,
                                 input logic resume);
        logic [4:0] got, e;
        do_reset();
        sb.push_back(IDLE_VEC);
        if (resume) begin
            for (int j = 0; j < 16; j++) sb.push_back(wave(4, j % 4, 1'b1, 1'b0));
        end else begin
            for (int j = 0; j < 8; j++) sb.push_back(wave(4, j % 4, 1'b1, 1'b0));
            for (int j = 0; j < 3; j++) sb.push_back(IDLE_VEC);
        end
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 4;
            end
            if (i == 1) start = 1'b1;
            if (i == 7) begin
                stop  = 1'b1;
                start = both;
            end
            if (i == 8 && resume) start = 1'b1;
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, got, e);
            else
                passed++;
        end
        $display("txn %s: done", name);
    endtask

    task automatic test_stop();
        run_stop_case("stop", 1'b0, 1'b0);
    endtask

    task automatic test_stop_resume();
        run_stop_case("stop_resume", 1'b0, 1'b1);
    endtask

    task automatic test_start_stop_together();
        logic [4:0] got;
        // In IDLE, start+stop together must not start.
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        step();
        got = observed();
        checks++;
        if (got !== IDLE_VEC)
            $display("FAIL start_stop_idle: got %b expected %b", got, IDLE_VEC);
        else
            passed++;
        run_stop_case("start_stop_run", 1'b1, 1'b0);
    endtask

    // Reset mid-period with a pending divisor; afterwards D is the default.
    task automatic test_reset_mid();
        logic [4:0] got, e;
        do_reset();
        for (int j = 0; j < 5; j++) sb.push_back(wave(6, j, (j <= 2), 1'b0));
        sb.push_back(IDLE_VEC);
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            reset = 1'b0;
            if (i == 0) start = 1'b1;
            if (i == 3) begin
                cfg_valid   = 1'b1;
                cfg_divisor = 9;
            end
            if (i == 5) reset = 1'b1;
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL reset_mid cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
        reset = 1'b0;
        for (int j = 0; j < 13; j++) sb.push_back(wave(6, j % 6, 1'b1, 1'b0));
        for (int i = 0; sb.size() != 0; i++) begin
            idle_inputs();
            if (i == 0) start = 1'b1;
            step();
            e = sb.pop_front();
            got = observed();
            checks++;
            if (got !== e)
                $display("FAIL reset_restart cycle %0d: got %b expected %b", i, got, e);
            else
                passed++;
        end
`ifdef CLKCTRL_PERIOD_COUNT_EN
        checks++;
        if (period_count !== 16'd3)
            $display("FAIL period_count: got %0d expected 3", period_count);
        else
            passed++;
`endif
        $display("txn reset_mid: pending discarded, D back to 6");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_default_run();
        test_idle_cfg();
        test_reconfig();
        test_cfg_error();
        test_stop();
        test_stop_resume();
        test_start_stop_together();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/clock_divider_ctrl.md
# clock_divider_ctrl

Run-time controller for the slowed-down clock path. Generates a divided clock and a one-cycle period tick from the fast FPGA clock, with a start/stop state machine and a valid/ready configuration port. The divisor can be reprogrammed while running: a new value is applied only at a period boundary, so no runt or stretched pulse is ever produced. It sits between control logic (or a register interface) and the logic clocked or enabled by the slow clock.

## Interface
- WIDTH, 28, width of the divisor and period counter.
- DEFAULT_DIVISOR, 100000, active divisor after reset.
- MIN_DIVISOR, 2, smallest legal divisor. Must be ≥2.

- clock_in  in  1  fast input clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request to begin or resume dividing.
- stop  in  1  level-sampled request to stop at the end of the current period.
- cfg_valid  in  1  new divisor offered.
- cfg_divisor  in  WIDTH  offered divisor, unsigned.
- cfg_ready  out  1  controller can accept a divisor.
- cfg_error  out  1  one-cycle pulse: the last accepted divisor was illegal and was discarded.
- clock_out  out  1  divided clock.
- tick  out  1  high for the first fast cycle of every slow period.
- running  out  1  high in RUN and STOPPING.
- period_count  out  16  slow periods started. Present only with the macro.

## Operation
- All outputs are registered. Reset values:
  - clock_out=0, tick=0, running=0, cfg_ready=1, cfg_error=0, period_count=0.
  - Internal: state=IDLE, counter=0, active divisor D=DEFAULT_DIVISOR, pending slot empty.
- States:
  - IDLE: outputs low, counter held at 0.
  - RUN: counter steps 0..D-1 and wraps to 0.
  - STOPPING: like RUN, but returns to IDLE when the period ends.
- Transitions:
  - IDLE→RUN on start.
  - RUN→STOPPING on stop.
  - STOPPING→RUN on start without stop; the counter is not disturbed.
  - STOPPING→IDLE at the period end (edge where counter=D-1).
- Ignored requests:
  - stop in IDLE.
  - start in RUN.
  - start and stop in the same cycle: stop wins.
- Waveform for each period of D cycles:
  - clock_out=1 for the first floor(D/2) cycles, then 0 for the remaining D-floor(D/2) cycles.
  - tick=1 only in the cycle where counter=0.
- Configuration handshake: a transfer happens on any edge with cfg_valid && cfg_ready.
  - Value < MIN_DIVISOR: discarded; cfg_error=1 in the next cycle; D unchanged; cfg_ready stays 1.
  - IDLE: D is updated at the transfer edge.
  - RUN or STOPPING: the value is stored as pending and cfg_ready drops to 0. At the period end it is copied to D, and the next period uses it. cfg_ready returns to 1 in the cycle after the copy.
  - Pending value present when entering IDLE: applied at that same period-end edge.
- Counter arithmetic is WIDTH bits, unsigned. The compare uses D>>1. Largest legal divisor is 2^WIDTH-1.
- Reset asserted mid-period: everything returns to reset values on that edge, the pending value is lost, and there is no partial-period completion.

## Timing
- start sampled at edge k in IDLE → in the cycle after k: running=1, tick=1, clock_out=1, counter=0.
- Period end (counter=D-1) in STOPPING → the next cycle has running=0, clock_out=0, tick=0.
- Config accepted in IDLE at edge k → a start at edge k or later uses the new D.
- Config accepted in RUN → takes effect at the first period boundary after acceptance. Worst-case latency is D_old cycles.
- cfg_error appears exactly 1 cycle after the rejecting edge and lasts 1 cycle.

## Configuration
- CLKCTRL_PERIOD_COUNT_EN:
  - Defined: period_count exists. It increments by 1 on every edge that sets tick=1, wraps 16'hFFFF→0, and clears only on reset.
  - Undefined: the port and counter are removed.
  - All other behaviour is identical either way.

## Test plan
- Reset, start with DEFAULT_DIVISOR overridden to 6 → clock_out repeats 1,1,1,0,0,0; tick on every 6th cycle; running=1.
- In IDLE, cfg_divisor=5, then start → pattern 1,1,0,0,0; cfg_ready stays 1 throughout.
- RUN with D=8, cfg_divisor=4 offered at counter=2 → cfg_ready low for 6 cycles; the current period completes 8 cycles; the next periods are 1,1,0,0.
- cfg_divisor=1 offered → cfg_error pulses once; D unchanged; the waveform is undisturbed.
- RUN with D=4, stop at counter=1 → the period finishes; running=0 two cycles later. Repeat with start asserted at counter=2 of the stopping period → no gap, RUN continues. Repeat with start+stop together in RUN → stop wins.
- Reset asserted mid-period with a pending divisor → all outputs take reset values on the next cycle; after start, D=DEFAULT_DIVISOR. With the macro, period_count=3 after three ticks.
